// File: rtl/ws2812_pkg.sv
// Shared types and default 12 MHz timing for the WS2812 receiver.
package ws2812_pkg;

   typedef enum logic [2:0] {
      SYNC,
      IDLE,
      HIGH,
      LOW,
      ERR
   } state_t;

   // Pulse-width limits in clk cycles at 12 MHz (tx: 1 = 10 high, 0 = 5 high).
   localparam int unsigned DEF_T_THRESH    = 7;
   localparam int unsigned DEF_T_HIGH_MIN  = 2;
   localparam int unsigned DEF_T_HIGH_MAX  = 20;
   localparam int unsigned DEF_T_RESET_MIN = 300;

   localparam int unsigned WORD_BITS = 24;

endpackage

// File: rtl/ws2812_edge_sync.sv
// Two-flop synchroniser for the asynchronous data line plus edge detect.
module ws2812_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic din_s,
   output logic rise_c,
   output logic fall_c
);

   logic meta;
   logic din_d;

   // Synchronise din and keep one cycle of history for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta  <= 1'b0;
         din_s <= 1'b0;
         din_d <= 1'b0;
      end else begin
         meta  <= din;
         din_s <= meta;
         din_d <= din_s;
      end
   end

   assign rise_c = din_s & ~din_d;
   assign fall_c = ~din_s & din_d;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: measures high widths, assembles 24-bit words.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int unsigned T_THRESH    = DEF_T_THRESH,
   parameter int unsigned T_HIGH_MIN  = DEF_T_HIGH_MIN,
   parameter int unsigned T_HIGH_MAX  = DEF_T_HIGH_MAX,
   parameter int unsigned T_RESET_MIN = DEF_T_RESET_MIN,
   parameter int unsigned IDX_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue,
   output logic [IDX_W-1:0] led_index,
   output logic             valid,
   output logic             frame_end,
   output logic             error
);

   localparam int unsigned LOW_W  = $clog2(T_RESET_MIN + 1);
   localparam int unsigned HIGH_W = $clog2(T_HIGH_MAX + 2);
   localparam int unsigned BIT_W  = $clog2(WORD_BITS + 1);

   logic din_s;
   logic rise_c;
   logic fall_c;

   state_t               state_q,    state_d;
   logic [LOW_W-1:0]     low_cnt_q,  low_cnt_d;
   logic [HIGH_W-1:0]    high_cnt_q, high_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
   logic [WORD_BITS-1:0] shift_q,    shift_d;
   logic [IDX_W-1:0]     word_cnt_q, word_cnt_d;
   logic [7:0]           red_d, green_d, blue_d;
   logic [IDX_W-1:0]     led_index_d;
   logic                 valid_d, frame_end_d, error_d;

   logic [LOW_W-1:0]     low_inc;
   logic [HIGH_W-1:0]    high_inc;
   logic                 gap_done;
   logic                 bit_c;
   logic [WORD_BITS-1:0] word_c;

   ws2812_edge_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .din    (din),
      .din_s  (din_s),
      .rise_c (rise_c),
      .fall_c (fall_c)
   );

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= SYNC;
         low_cnt_q  <= '0;
         high_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         word_cnt_q <= '0;
         red        <= '0;
         green      <= '0;
         blue       <= '0;
         led_index  <= '0;
         valid      <= 1'b0;
         frame_end  <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_q    <= state_d;
         low_cnt_q  <= low_cnt_d;
         high_cnt_q <= high_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         word_cnt_q <= word_cnt_d;
         red        <= red_d;
         green      <= green_d;
         blue       <= blue_d;
         led_index  <= led_index_d;
         valid      <= valid_d;
         frame_end  <= frame_end_d;
         error      <= error_d;
      end
   end

   // Next-state decode: pulse classification, word assembly, frame/gap handling.
   always_comb begin
      state_d     = state_q;
      low_cnt_d   = low_cnt_q;
      high_cnt_d  = high_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      word_cnt_d  = word_cnt_q;
      red_d       = red;
      green_d     = green;
      blue_d      = blue;
      led_index_d = led_index;
      valid_d     = 1'b0;
      frame_end_d = 1'b0;
      error_d     = 1'b0;

      low_inc  = (low_cnt_q >= LOW_W'(T_RESET_MIN)) ? low_cnt_q : low_cnt_q + LOW_W'(1);
      high_inc = (high_cnt_q > HIGH_W'(T_HIGH_MAX)) ? high_cnt_q : high_cnt_q + HIGH_W'(1);
      gap_done = (low_inc >= LOW_W'(T_RESET_MIN));
      bit_c    = (high_cnt_q > HIGH_W'(T_THRESH));
      word_c   = {shift_q[WORD_BITS-2:0], bit_c};

      unique case (state_q)
         // SYNC and ERR only leave once a full reset gap has been seen.
         SYNC, ERR: begin
            if (din_s) begin
               low_cnt_d = '0;
            end else if (gap_done) begin
               low_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               low_cnt_d = low_inc;
            end
         end

         IDLE: begin
            if (rise_c) begin
               high_cnt_d = HIGH_W'(1);
               state_d    = HIGH;
            end
         end

         HIGH: begin
            if (fall_c) begin
               if (high_cnt_q < HIGH_W'(T_HIGH_MIN)) begin
                  error_d    = 1'b1;
                  shift_d    = '0;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
                  low_cnt_d  = LOW_W'(1);
                  state_d    = ERR;
               end else begin
                  low_cnt_d = LOW_W'(1);
                  state_d   = LOW;
                  if (bit_cnt_q == BIT_W'(WORD_BITS - 1)) begin
                     // Word complete: publish now so a rise next cycle starts clean.
                     red_d       = word_c[23:16];
                     green_d     = word_c[15:8];
                     blue_d      = word_c[7:0];
                     led_index_d = word_cnt_q;
                     valid_d     = 1'b1;
                     word_cnt_d  = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + IDX_W'(1);
                     bit_cnt_d   = '0;
                     shift_d     = '0;
                  end else begin
                     shift_d   = word_c;
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end
            end else begin
               high_cnt_d = high_inc;
               if (high_inc > HIGH_W'(T_HIGH_MAX)) begin
                  error_d    = 1'b1;
                  shift_d    = '0;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
                  low_cnt_d  = '0;
                  state_d    = ERR;
               end
            end
         end

         LOW: begin
            if (rise_c) begin
               high_cnt_d = HIGH_W'(1);
               state_d    = HIGH;
            end else if (gap_done) begin
               // Latch gap: close the frame, flag any partial word.
               frame_end_d = 1'b1;
               error_d     = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
               shift_d     = '0;
               word_cnt_d  = '0;
               led_index_d = '0;
               low_cnt_d   = '0;
               state_d     = IDLE;
            end else begin
               low_cnt_d = low_inc;
            end
         end

         default: state_d = SYNC;
      endcase
   end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: vector table, corner sequences, random frames.
module tb_ws2812_rx;

   localparam int unsigned IDX_W   = 3;
   localparam int          IDX_MAX = (1 << IDX_W) - 1;
   localparam int          THRESH  = 7;
   localparam int          HMIN    = 2;
   localparam int          HMAX    = 20;

   typedef struct packed {
      logic             v;
      logic             fe;
      logic             er;
      logic [23:0]      rgb;
      logic [IDX_W-1:0] idx;
   } ev_t;

   typedef struct {
      logic [23:0] word;
      int          hi1;
      int          hi0;
      int          lo;
      logic        err;
      logic [23:0] exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             din;
   logic [7:0]       red, green, blue;
   logic [IDX_W-1:0] led_index;
   logic             valid, frame_end, error;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   ev_t got_q[$];
   int  got_t[$];
   ev_t exp_q[$];
   int  wq[$];
   int  lq[$];
   int  rise_t[$];
   int  fall_t[$];

   logic [23:0]      m_rgb;
   logic [IDX_W-1:0] m_idx;

   vec_t vt[7];

   ws2812_rx #(.IDX_W(IDX_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .led_index (led_index),
      .valid     (valid),
      .frame_end (frame_end),
      .error     (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input logic v, input logic fe, input logic er,
                              input logic [23:0] rgb, input logic [IDX_W-1:0] idx);
      ev_t e;
      e.v = v; e.fe = fe; e.er = er; e.rgb = rgb; e.idx = idx;
      return e;
   endfunction

   // Record every strobe with the bench cycle it was seen on.
   always @(negedge clk) begin
      if (!reset && (valid || frame_end || error)) begin
         got_q.push_back(mk(valid, frame_end, error, {red, green, blue}, led_index));
         got_t.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_frame(input string name);
      check({name, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s ev%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete(); got_t.delete(); exp_q.delete();
   endtask

   task automatic clear_frame();
      wq.delete(); lq.delete(); rise_t.delete(); fall_t.delete();
   endtask

   task automatic add_word(input logic [23:0] w, input int hi1, input int hi0, input int lo);
      for (int b = 23; b >= 0; b--) begin
         wq.push_back(w[b] ? hi1 : hi0);
         lq.push_back(lo);
      end
   endtask

   task automatic add_rand_bits(input int n, input int lo_max);
      for (int b = 0; b < n; b++) begin
         wq.push_back(($urandom_range(1, 0) == 1) ? int'($urandom_range(20, 8)) : int'($urandom_range(7, 2)));
         lq.push_back(int'($urandom_range(lo_max, 1)));
      end
   endtask

   // Drive the queued pulses (entered and left on a negedge), then a low gap.
   task automatic send_frame(input int gap);
      foreach (wq[i]) begin
         din = 1'b1;
         rise_t.push_back(cyc);
         repeat (wq[i]) @(negedge clk);
         din = 1'b0;
         fall_t.push_back(cyc);
         repeat (lq[i]) @(negedge clk);
      end
      repeat (gap) @(negedge clk);
   endtask

   // Reference: classify each pulse width, group bits into words, close on the gap.
   task automatic model_frame();
      int          nb;
      int          cnt;
      logic [23:0] acc;
      nb = 0; cnt = 0; acc = '0;
      foreach (wq[i]) begin
         if (wq[i] < HMIN || wq[i] > HMAX) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, m_rgb, m_idx));
            return;
         end
         acc = {acc[22:0], (wq[i] > THRESH)};
         nb++;
         if (nb == 24) begin
            m_rgb = acc;
            m_idx = IDX_W'((cnt > IDX_MAX) ? IDX_MAX : cnt);
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, m_rgb, m_idx));
            cnt++;
            nb = 0;
         end
      end
      m_idx = '0;
      exp_q.push_back(mk(1'b0, 1'b1, (nb != 0), m_rgb, m_idx));
   endtask

   initial begin
      vt[0] = '{24'hFF8001, 10, 5, 6,  1'b0, 24'hFF8001};
      vt[1] = '{24'hA5C33C, 8,  7, 6,  1'b0, 24'hA5C33C};
      vt[2] = '{24'h5A5A5A, 20, 2, 1,  1'b0, 24'h5A5A5A};
      vt[3] = '{24'hFFFFFF, 7,  5, 6,  1'b0, 24'h000000};
      vt[4] = '{24'h00F000, 10, 1, 6,  1'b1, 24'h000000};
      vt[5] = '{24'h800000, 21, 5, 6,  1'b1, 24'h000000};
      vt[6] = '{24'h123456, 10, 5, 40, 1'b0, 24'h123456};

      m_rgb = '0; m_idx = '0;
      reset = 1'b1; din = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_rgb", 64'({red, green, blue}), 64'(0));
      check("reset_idx", 64'(led_index), 64'(0));
      check("reset_strobes", 64'({valid, frame_end, error}), 64'(0));
      reset = 1'b0;

      // Pulses before the first gap must be ignored.
      clear_frame();
      add_word(24'hFFFF00, 10, 5, 6);
      add_rand_bits(10, 8);
      send_frame(350);
      check_frame("startup");

      // Single word with latency checks.
      clear_frame();
      add_word(24'hFF8001, 10, 5, 6);
      model_frame();
      send_frame(600);
      if (got_t.size() == 2) begin
         check("valid_lat", 64'(got_t[0] - fall_t[23]), 64'(3));
         check("fe_lat", 64'(got_t[1] - fall_t[23]), 64'(302));
      end
      check_frame("single");

      // Three words in one frame, then a new frame restarting at index 0.
      clear_frame();
      add_word(24'h000000, 10, 5, 6);
      add_word(24'hFFFFFF, 10, 5, 6);
      add_word(24'h123456, 10, 5, 6);
      model_frame();
      send_frame(320);
      check_frame("three");
      clear_frame();
      add_word(24'hC0FFEE, 10, 5, 6);
      model_frame();
      send_frame(320);
      check_frame("restart");

      for (int i = 0; i < 7; i++) begin
         clear_frame();
         add_word(vt[i].word, vt[i].hi1, vt[i].hi0, vt[i].lo);
         if (vt[i].err) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, m_rgb, m_idx));
         end else begin
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, vt[i].exp, '0));
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, vt[i].exp, '0));
            m_rgb = vt[i].exp;
            m_idx = '0;
         end
         send_frame(320);
         check_frame($sformatf("vec%0d", i));
      end

      // Partial word closed by a gap.
      clear_frame();
      add_rand_bits(12, 8);
      model_frame();
      send_frame(600);
      check_frame("partial");

      // Overlong high mid-word, then a clean frame.
      clear_frame();
      add_rand_bits(5, 6);
      wq.push_back(25); lq.push_back(6);
      add_rand_bits(10, 6);
      model_frame();
      send_frame(320);
      if (got_t.size() == 1) check("long_high_lat", 64'(got_t[0] - rise_t[5]), 64'(23));
      check_frame("long_high");
      clear_frame();
      add_word(24'h0F1E2D, 10, 5, 6);
      model_frame();
      send_frame(320);
      check_frame("after_long");

      // Index saturation over ten words.
      clear_frame();
      for (int w = 0; w < 10; w++) add_word(24'($urandom()) | 24'h000001, 10, 5, 2);
      model_frame();
      send_frame(320);
      check_frame("saturate");

      // Asynchronous reset mid-word.
      clear_frame();
      add_rand_bits(10, 6);
      send_frame(0);
      reset = 1'b1;
      #1;
      check("async_reset", 64'({red, green, blue, led_index, valid, frame_end, error}), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      m_rgb = '0; m_idx = '0;
      check_frame("reset_mid");
      repeat (320) @(negedge clk);
      clear_frame();
      add_word(24'h3C5A96, 10, 5, 6);
      model_frame();
      send_frame(320);
      check_frame("after_reset");

      // Random frames, occasionally partial or with a bad pulse.
      for (int f = 0; f < 16; f++) begin
         int nw;
         clear_frame();
         nw = int'($urandom_range(9, 1));
         add_rand_bits(nw * 24, 8);
         if ($urandom_range(4, 0) == 0) add_rand_bits(int'($urandom_range(23, 1)), 8);
         if ($urandom_range(7, 0) == 0)
            wq[$urandom_range(wq.size() - 1, 0)] = ($urandom_range(1, 0) == 1) ? 1 : int'($urandom_range(24, 21));
         model_frame();
         send_frame(320);
         check_frame($sformatf("rand%0d", f));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812 receiver/decoder, the receive end of the team's ws2812 transmitter.
- Recovers 24-bit colour words from the serial data line by measuring high-pulse widths against the clock.
- Presents each word as red/green/blue with an LED index, plus end-of-frame and error strobes.
- Used for loopback checking of the transmitter on hardware and as a front end for daisy-chained FPGA "pixel" nodes.

Parameters:
- T_THRESH, 7: high width in clk cycles; width > T_THRESH decodes as 1, otherwise 0 (12 MHz: tx 1 = 10 cycles, 0 = 5 cycles).
- T_HIGH_MIN, 2: high width below this is a glitch and flags an error.
- T_HIGH_MAX, 20: high width above this flags an error.
- T_RESET_MIN, 300: continuous low cycles that constitute the reset/latch gap (25 us at 12 MHz).
- IDX_W, 8: width of led_index.

Ports:
- clk  in  1  system clock, 12 MHz.
- reset  in  1  asynchronous, active-high reset.
- din  in  1  serial WS2812 data line, asynchronous to clk.
- red  out  8  decoded red byte, held until the next valid.
- green  out  8  decoded green byte, held until the next valid.
- blue  out  8  decoded blue byte, held until the next valid.
- led_index  out  IDX_W  position in frame of the word on red/green/blue, first word = 0.
- valid  out  1  one-cycle strobe: new word on red/green/blue/led_index.
- frame_end  out  1  one-cycle strobe: reset gap detected after at least one bit.
- error  out  1  one-cycle strobe: timing violation or partial word.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values: red/green/blue = 0, led_index = 0, valid/frame_end/error = 0, state = SYNC, all counters 0.
- Input conditioning: din passes through a 2-FF synchroniser to give din_s; rise/fall are derived from din_s and its previous value.
- Latency: all decisions are made on din_s, which lags din by 2 cycles.
- Bit order: the first bit received is word[23]. word = {red, green, blue}, MSB first.
- States:
  - SYNC (after reset): low_cnt counts consecutive din_s==0 cycles and clears on din_s==1. Reaching T_RESET_MIN goes to IDLE. Rises before that are ignored, so start-up mid-frame is never decoded.
  - IDLE: waits for rise, then goes to HIGH with high_cnt = 1.
  - HIGH: high_cnt increments each cycle din_s==1.
    - high_cnt exceeding T_HIGH_MAX: pulse error, go to ERR.
    - On fall: high_cnt < T_HIGH_MIN → pulse error, go to ERR.
    - Otherwise shift bit (high_cnt > T_THRESH) into the shift register, bit_cnt++, low_cnt = 1, go to LOW.
  - LOW: low_cnt increments while low.
    - On rise: go to HIGH with high_cnt = 1.
    - low_cnt reaching T_RESET_MIN: end of frame, go to IDLE.
  - ERR: discards everything; behaves like SYNC (waits for a T_RESET_MIN low gap), then goes to IDLE. Neither frame_end nor led_index increments are produced for an aborted frame.
- Word completion:
  - When the 24th bit is shifted in, the next cycle latches red/green/blue/led_index, pulses valid, and sets bit_cnt = 0.
  - led_index increments after each valid and saturates at 2^IDX_W-1; it does not wrap.
- End of frame (LOW reaching T_RESET_MIN):
  - bit_cnt == 0: pulse frame_end, clear led_index to 0.
  - bit_cnt != 0: pulse error and frame_end, drop the partial word, clear led_index.
- Simultaneous events: the 24th bit's valid and a rise one cycle later are both handled, because the shift register and bit_cnt are already cleared. valid, frame_end and error never coincide except for the partial-word case.
- Counter widths: $clog2(T_RESET_MIN+1) for low_cnt, $clog2(T_HIGH_MAX+2) for high_cnt; both saturate, never wrap.
- Reset mid-frame: outputs clear immediately (asynchronous) and the block returns to SYNC.

Decomposition:
- Package ws2812_pkg:
  - state enum: SYNC, IDLE, HIGH, LOW, ERR.
  - default timing constants: T_THRESH, T_HIGH_MIN, T_HIGH_MAX, T_RESET_MIN at 12 MHz.
  - WORD_BITS = 24.
- Sub-module ws2812_edge_sync: 2-FF synchroniser plus rise/fall detect, async reset to 0.

Test Plan:
- Hold din low 300 cycles, then send 24 bits of 0xFF8001 (1 = 10 high/6 low, 0 = 5 high/11 low), then 600 low → valid once with red=0xFF, green=0x80, blue=0x01, led_index=0; frame_end 300 cycles after the last fall; error never.
- Same preamble, then 3 words 0x000000, 0xFFFFFF, 0x123456, then a gap → three valid strobes with led_index 0,1,2 and correct bytes; one frame_end; next frame starts at index 0.
- Rising edges and bits arrive before any 300-cycle low after reset → no valid, no error; decoding starts only after the first gap.
- 12 bits, then a 600-cycle low → error and frame_end pulse together, no valid, outputs unchanged.
- High held for 25 cycles mid-word → error when high_cnt reaches 21; subsequent bits ignored until 300 low; the following frame decodes normally.
- 1-cycle glitch high → error; assert reset for 1 cycle mid-word → all outputs 0 immediately, the block re-enters SYNC, and the next frame decodes correctly.
